// File: rtl/fifo_tx_drain_if.sv
// Handshake bundle between the FIFO read side / UART TX and the drain FSM.
// master = drain logic, slave = FIFO + transmitter environment.
interface fifo_tx_drain_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_inc;
  logic          tx_busy;
  logic [DW-1:0] tx_data;
  logic          tx_data_valid;
  logic [CW-1:0] sent_cnt;
  logic          tx_err;
  logic [1:0]    fsm_state;

  // tx_data_valid is a request held until tx_busy is observed high; the word is
  // accepted on that edge and completed on the first later edge with tx_busy low.
  modport master (
    input  fifo_empty, fifo_rd_data, tx_busy,
    output fifo_rd_inc, tx_data, tx_data_valid, sent_cnt, tx_err, fsm_state
  );

  modport slave (
    output fifo_empty, fifo_rd_data, tx_busy,
    input  fifo_rd_inc, tx_data, tx_data_valid, sent_cnt, tx_err, fsm_state
  );
endinterface

// File: rtl/fifo_tx_drain.sv
// Pops one FIFO word at a time and hands it to the UART TX via valid/busy.
// Optional handshake timeout enabled by defining DRAIN_TIMEOUT_EN.
module fifo_tx_drain #(
  parameter int DW      = 8,
  parameter int CW      = 8,
  parameter int TMO_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  fifo_tx_drain_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  if (TMO_CYC < 1 || TMO_CYC > 65535) begin : g_tmo_range
    $error("fifo_tx_drain: TMO_CYC out of range 1..65535");
  end

  state_t        state;
  logic          rd_inc;
  logic [DW-1:0] data;
  logic          valid;
  logic [CW-1:0] cnt;
  logic          err;

`ifdef DRAIN_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      rd_inc  <= 1'b0;
      data    <= '0;
      valid   <= 1'b0;
      cnt     <= '0;
      err     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      rd_inc <= 1'b0;
      err    <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.fifo_empty && !bus.tx_busy) begin
            data    <= bus.fifo_rd_data;
            rd_inc  <= 1'b1;
            valid   <= 1'b1;
            tmo_cnt <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_busy) begin
            valid <= 1'b0;
            state <= WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            // Counter would reach TMO_CYC on this edge: drop the word.
            valid <= 1'b0;
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        WAIT: begin
          if (!bus.tx_busy) begin
            cnt   <= cnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rd_inc <= 1'b0;
      data   <= '0;
      valid  <= 1'b0;
      cnt    <= '0;
    end else begin
      rd_inc <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.fifo_empty && !bus.tx_busy) begin
            data   <= bus.fifo_rd_data;
            rd_inc <= 1'b1;
            valid  <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_busy) begin
            valid <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // Busy was already seen high, so a low level here is the falling edge.
          if (!bus.tx_busy) begin
            cnt   <= cnt + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign err = 1'b0;
`endif

  assign bus.fifo_rd_inc   = rd_inc;
  assign bus.tx_data       = data;
  assign bus.tx_data_valid = valid;
  assign bus.sent_cnt      = cnt;
  assign bus.tx_err        = err;
  assign bus.fsm_state     = state;

endmodule

// File: doc/fifo_tx_drain.md
# fifo_tx_drain

Read-side consumer for the asynchronous data FIFO. It lives in the FIFO's read-clock domain (the UART TX clock domain). It pops one word at a time from the FIFO and presents it to the UART transmitter using a valid/busy handshake. It paces pops so that no word is read until the transmitter has accepted and finished the previous one.

## Interface
- DW, 8, data width; matches the FIFO data width.
- CW, 8, width of the sent-word counter.
- TMO_CYC, 255, maximum cycles to wait for tx_busy to rise (used only with DRAIN_TIMEOUT_EN); legal range 1..2^16-1.

- clk  in  1  read-domain clock, the same clock as the FIFO read side.
- rst  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag from the read side.
- fifo_rd_data  in  DW  FIFO read data; valid whenever fifo_empty=0.
- fifo_rd_inc  out  1  one-cycle pop strobe, driven to the FIFO rd_flag.
- tx_busy  in  1  UART TX busy; high while a frame is shifting out.
- tx_data  out  DW  registered word presented to UART TX.
- tx_data_valid  out  1  request to UART TX; held until tx_busy is seen high.
- sent_cnt  out  CW  count of words completed (busy fell), wraps modulo 2^CW.
- tx_err  out  1  one-cycle pulse when a handshake times out (only with DRAIN_TIMEOUT_EN).

## Operation
- Three-state FSM: IDLE, SEND, WAIT. Reset state is IDLE.
- **IDLE**
  - Condition: fifo_empty=0 and tx_busy=0 at a clock edge.
  - Action: tx_data <= fifo_rd_data, fifo_rd_inc <= 1 for exactly one cycle, tx_data_valid <= 1, go to SEND.
  - Otherwise stay in IDLE with all strobes at 0.
- **SEND**
  - tx_data_valid stays 1 and tx_data stays stable.
  - On the first edge with tx_busy=1: tx_data_valid <= 0, go to WAIT.
- **WAIT**
  - On the first edge with tx_busy=0: sent_cnt <= sent_cnt+1, go to IDLE.
- Exactly one pop per transmitted word. fifo_rd_inc is never asserted outside the IDLE->SEND transition.
- fifo_empty is sampled only in IDLE. Because at least SEND and WAIT intervene, the FIFO's updated empty flag is always settled before the next sample.
- tx_busy already high in IDLE (transmitter in use by another source): no pop occurs until it is low.
- sent_cnt wraps from 2^CW-1 to 0 with no flag.
- An asynchronous reset mid-operation returns the FSM to IDLE and clears all outputs.
  - A word already popped but not yet accepted is lost.
  - The FIFO pointer is not rewound.

## Timing
- Reset values: fifo_rd_inc=0, tx_data=0, tx_data_valid=0, sent_cnt=0, tx_err=0.
- All outputs are registered; there are no combinational paths from input to output.
- Pop latency:
  - Edge N samples fifo_empty=0 in IDLE.
  - fifo_rd_inc and tx_data_valid are high from edge N to edge N+1 (fifo_rd_inc for that cycle only).
  - tx_data is valid from edge N.
- Word-to-word minimum is 3 cycles (IDLE->SEND->WAIT->IDLE), with tx_busy rising at the first SEND edge and falling at the first WAIT edge.
- tx_busy is a level input; no edge detector is needed because WAIT is entered only after busy has been seen high.

## Configuration
- Macro: DRAIN_TIMEOUT_EN.
- **Defined**
  - A 16-bit counter clears on SEND entry and increments each cycle in SEND.
  - If it reaches TMO_CYC with tx_busy still 0:
    - tx_data_valid <= 0.
    - tx_err pulses for one cycle.
    - FSM goes to IDLE, the word is dropped, and sent_cnt is unchanged.
- **Undefined**
  - SEND waits indefinitely.
  - tx_err is tied to 0 and no counter is synthesised.

## Test plan
- Reset with fifo_empty=0: all outputs stay 0 while rst=0; the first pop occurs on the first edge after release.
- FIFO holding 0xA5, 0x3C, transmitter model busy for 10 cycles one cycle after valid:
  - tx_data sequence is 0xA5 then 0x3C.
  - Exactly 2 fifo_rd_inc pulses, each 1 cycle wide.
  - sent_cnt=2; fifo_empty then stays 1 with no further pops.
- tx_busy held 1 for 20 cycles with FIFO non-empty: no pop until busy falls, then pop on the next edge.
- Fast transmitter (busy for 1 cycle) with 8 queued words: pops are spaced exactly 3 cycles apart and sent_cnt=8.
- CW=4, 17 words sent: sent_cnt wraps to 1.
- DRAIN_TIMEOUT_EN with TMO_CYC=5 and tx_busy stuck at 0:
  - tx_data_valid drops after 5 SEND cycles.
  - tx_err pulses once and sent_cnt is unchanged.
  - The next word is popped from IDLE.
